// File: rtl/sig_switch_nch.sv
// N-channel, WIDTH-bit registered signal switch: per-bit synchronisers plus a valid/ready select
// handshake with break-before-make blanking. Optional macro SWITCH_HOLD_LAST_EN holds OUT while blanking.
module sig_switch_nch #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int RESET_SEL   = 0,
  localparam int SEL_W      = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_CH*WIDTH-1:0] IN_DATA,
  input  logic                    SEL_VALID,
  input  logic [SEL_W-1:0]        SEL_IN,
  output logic                    SEL_READY,
  output logic                    SEL_DONE,
  output logic                    SEL_ERR,
  output logic [SEL_W-1:0]        ACTIVE_SEL,
  output logic [WIDTH-1:0]        OUT,
  output logic                    OUT_VALID
);
  localparam int CNT_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [0:0] {ROUTE = 1'b0, BLANK = 1'b1} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic [SEL_W-1:0]          pending, pending_nxt;
  logic [SEL_W-1:0]          active_nxt, mux_sel;
  logic [WIDTH-1:0]          out_nxt, route_data, blank_data;
  logic                      valid_nxt, done_nxt, err_nxt, ready_nxt, sel_in_range;
  logic [NUM_CH*WIDTH-1:0]   sync_chain [SYNC_STAGES];
  logic [NUM_CH*WIDTH-1:0]   synced;

  // synchroniser chain, one flop per stage per input bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_chain[i] <= '0;
    end else begin
      sync_chain[0] <= IN_DATA;
      for (int i = 1; i < SYNC_STAGES; i++) sync_chain[i] <= sync_chain[i-1];
    end
  end

  assign synced       = sync_chain[SYNC_STAGES-1];
  assign sel_in_range = (int'(SEL_IN) < NUM_CH);

  // while blanking the mux already points at the pending channel so the exit cycle carries new data
  always_comb begin
    mux_sel    = (state == BLANK) ? pending : ACTIVE_SEL;
    route_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      route_data = (mux_sel == SEL_W'(c)) ? synced[c*WIDTH +: WIDTH] : route_data;
    end
`ifdef SWITCH_HOLD_LAST_EN
    blank_data = OUT;
`else
    blank_data = '0;
`endif
  end

  // next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    active_nxt  = ACTIVE_SEL;
    out_nxt     = route_data;
    valid_nxt   = 1'b1;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      ROUTE: begin
        if (SEL_VALID && SEL_READY) begin
          if (!sel_in_range) begin
            err_nxt = 1'b1;
          end else if (SEL_IN == ACTIVE_SEL) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt   = BLANK;
            cnt_nxt     = CNT_W'(GAP_CYCLES - 1);
            pending_nxt = SEL_IN;
            out_nxt     = blank_data;
            valid_nxt   = 1'b0;
          end
        end else begin
          state_nxt = ROUTE;
        end
      end
      BLANK: begin
        if (cnt == '0) begin
          state_nxt  = ROUTE;
          active_nxt = pending;
          done_nxt   = 1'b1;
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
          out_nxt   = blank_data;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = ROUTE;
      end
    endcase
    ready_nxt = (state_nxt == ROUTE);
  end

  // state and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ROUTE;
      cnt        <= '0;
      pending    <= SEL_W'(RESET_SEL);
      ACTIVE_SEL <= SEL_W'(RESET_SEL);
      OUT        <= '0;
      OUT_VALID  <= 1'b0;
      SEL_DONE   <= 1'b0;
      SEL_ERR    <= 1'b0;
      SEL_READY  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pending    <= pending_nxt;
      ACTIVE_SEL <= active_nxt;
      OUT        <= out_nxt;
      OUT_VALID  <= valid_nxt;
      SEL_DONE   <= done_nxt;
      SEL_ERR    <= err_nxt;
      SEL_READY  <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_sig_switch_nch.sv
// Self-checking bench for sig_switch_nch (NUM_CH=3): directed scenarios plus random traffic
// against a timestamp-based reference model; follows SWITCH_HOLD_LAST_EN for blank values.
module tb_sig_switch_nch;
  localparam int NUM_CH = 3, WIDTH = 8, SYNC_STAGES = 2, GAP_CYCLES = 2, RESET_SEL = 0;
  localparam int SEL_W = 2, DW = NUM_CH * WIDTH;
`ifdef SWITCH_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic             clk = 1'b0, rst = 1'b0, sel_valid = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic [SEL_W-1:0] sel_in = '0;
  logic             sel_ready, sel_done, sel_err, out_valid;
  logic [SEL_W-1:0] active_sel;
  logic [WIDTH-1:0] out;

  int total = 0, bad = 0;

  // reference model: input history by edge number, blanking tracked as an exit-edge timestamp
  logic [DW-1:0]    in_at [int];
  int               ecnt, blank_end, m_active, m_pending;
  logic [WIDTH-1:0] m_out;
  logic             m_valid, m_ready, m_done, m_err;

  sig_switch_nch #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES),
                   .GAP_CYCLES(GAP_CYCLES), .RESET_SEL(RESET_SEL)) dut (
    .CLK(clk), .RST(rst), .IN_DATA(in_data), .SEL_VALID(sel_valid), .SEL_IN(sel_in),
    .SEL_READY(sel_ready), .SEL_DONE(sel_done), .SEL_ERR(sel_err), .ACTIVE_SEL(active_sel),
    .OUT(out), .OUT_VALID(out_valid));

  always #10 clk = ~clk;

  function automatic logic [WIDTH-1:0] syn(input int ch, input int e);
    logic [DW-1:0] w;
    w = '0;
    if (in_at.exists(e - SYNC_STAGES)) w = in_at[e - SYNC_STAGES];
    return w[ch*WIDTH +: WIDTH];
  endfunction

  task automatic model_reset();
    in_at.delete();
    ecnt = 0; blank_end = -1; m_active = RESET_SEL; m_pending = RESET_SEL;
    m_out = '0; m_valid = 1'b0; m_ready = 1'b0; m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    int e = ecnt;
    m_done = 1'b0; m_err = 1'b0;
    if (blank_end > e) begin
      m_out = HOLD ? m_out : '0; m_valid = 1'b0; m_ready = 1'b0;
    end else if (blank_end == e) begin
      m_active = m_pending; m_done = 1'b1;
      m_out = syn(m_active, e); m_valid = 1'b1; m_ready = 1'b1;
    end else if (sel_valid && m_ready && int'(sel_in) < NUM_CH && int'(sel_in) != m_active) begin
      m_pending = int'(sel_in); blank_end = e + GAP_CYCLES;
      m_out = HOLD ? m_out : '0; m_valid = 1'b0; m_ready = 1'b0;
    end else begin
      if (sel_valid && m_ready) begin
        if (int'(sel_in) >= NUM_CH) m_err = 1'b1;
        else m_done = 1'b1;
      end
      m_out = syn(m_active, e); m_valid = 1'b1; m_ready = 1'b1;
    end
    in_at[e] = in_data;
    ecnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #5 rst = 1'b1;
    model_reset();
    in_data = '0; in_data[7:0] = 8'h5A;
    @(negedge clk); @(negedge clk);
    total++;
    if ({out, out_valid, sel_ready, sel_done, sel_err, active_sel} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      bad++; $display("FAIL reset_hold: out=%h v=%b r=%b a=%0d, want 00 0 0 0", out, out_valid, sel_ready, active_sel);
    end
    rst = 1'b0;
    for (int i = 0; i < SYNC_STAGES + 1; i++) begin
      tick();
      total++;
      if ({out, out_valid, sel_ready, sel_done, sel_err, active_sel} !== {m_out, m_valid, m_ready, m_done, m_err, SEL_W'(m_active)}) begin
        bad++; $display("FAIL reset_release[%0d]: got %h %b%b%b%b a=%0d want %h %b%b%b%b a=%0d", i,
          out, out_valid, sel_ready, sel_done, sel_err, active_sel, m_out, m_valid, m_ready, m_done, m_err, m_active);
      end
    end
    total++;
    if ({out, out_valid, sel_ready, active_sel} !== {8'h5A, 1'b1, 1'b1, 2'd0}) begin
      bad++; $display("FAIL reset_latency: out=%h v=%b r=%b a=%0d, want 5a 1 1 0", out, out_valid, sel_ready, active_sel);
    end
  endtask

  task automatic test_switch();
    in_data = {8'h33, 8'h22, 8'h11};
    repeat (4) tick();
    sel_valid = 1'b1; sel_in = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      sel_valid = 1'b0; sel_in = 2'd1;
      total++;
      if ({out, out_valid, sel_ready, sel_done, sel_err, active_sel} !== {m_out, m_valid, m_ready, m_done, m_err, SEL_W'(m_active)}) begin
        bad++; $display("FAIL switch_model[%0d]: got %h %b%b%b%b a=%0d want %h %b%b%b%b a=%0d", i,
          out, out_valid, sel_ready, sel_done, sel_err, active_sel, m_out, m_valid, m_ready, m_done, m_err, m_active);
      end
      total++;
      if (i < 2 && {out, out_valid, sel_ready, sel_done} !== {(HOLD ? 8'h11 : 8'h00), 1'b0, 1'b0, 1'b0}) begin
        bad++; $display("FAIL switch_blank[%0d]: out=%h v=%b r=%b d=%b", i, out, out_valid, sel_ready, sel_done);
      end else if (i == 2 && {out, out_valid, sel_done, active_sel} !== {8'h33, 1'b1, 1'b1, 2'd2}) begin
        bad++; $display("FAIL switch_exit: out=%h v=%b d=%b a=%0d, want 33 1 1 2", out, out_valid, sel_done, active_sel);
      end else if (i == 3 && sel_done !== 1'b0) begin
        bad++; $display("FAIL switch_done_width: done=%b want 0", sel_done);
      end
    end
  endtask

  task automatic test_same_channel();
    sel_valid = 1'b1; sel_in = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      sel_valid = 1'b0;
      total++;
      if ({out, out_valid, sel_ready, sel_done, sel_err, active_sel} !== {m_out, m_valid, m_ready, m_done, m_err, SEL_W'(m_active)}) begin
        bad++; $display("FAIL same_model[%0d]: got %h %b%b%b%b a=%0d want %h %b%b%b%b a=%0d", i,
          out, out_valid, sel_ready, sel_done, sel_err, active_sel, m_out, m_valid, m_ready, m_done, m_err, m_active);
      end
      total++;
      if ({out, out_valid, sel_done} !== {8'h33, 1'b1, (i == 0)}) begin
        bad++; $display("FAIL same_nogap[%0d]: out=%h v=%b d=%b", i, out, out_valid, sel_done);
      end
    end
  endtask

  task automatic test_reject();
    sel_valid = 1'b1; sel_in = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      sel_valid = 1'b0;
      total++;
      if ({out, out_valid, sel_ready, sel_done, sel_err, active_sel} !== {m_out, m_valid, m_ready, m_done, m_err, SEL_W'(m_active)}) begin
        bad++; $display("FAIL reject_model[%0d]: got %h %b%b%b%b a=%0d want %h %b%b%b%b a=%0d", i,
          out, out_valid, sel_ready, sel_done, sel_err, active_sel, m_out, m_valid, m_ready, m_done, m_err, m_active);
      end
      total++;
      if ({sel_err, sel_done, out_valid, active_sel} !== {(i == 0), 1'b0, 1'b1, 2'd2}) begin
        bad++; $display("FAIL reject_err[%0d]: err=%b done=%b v=%b a=%0d", i, sel_err, sel_done, out_valid, active_sel);
      end
    end
  endtask

  task automatic test_blank_value();
    sel_valid = 1'b1; sel_in = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      sel_valid = 1'b0;
      total++;
      if (i < 2 && {out, out_valid} !== {(HOLD ? 8'h33 : 8'h00), 1'b0}) begin
        bad++; $display("FAIL blank_value[%0d]: out=%h v=%b", i, out, out_valid);
      end else if (i >= 2 && {out, out_valid, active_sel} !== {8'h22, 1'b1, 2'd1}) begin
        bad++; $display("FAIL blank_exit[%0d]: out=%h v=%b a=%0d, want 22 1 1", i, out, out_valid, active_sel);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    sel_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sel_in = (m_active == 0) ? 2'd1 : 2'd0;
      tick();
      if (sel_done === 1'b1) dones++;
      total++;
      if ({out, out_valid, sel_ready, sel_done, sel_err, active_sel} !== {m_out, m_valid, m_ready, m_done, m_err, SEL_W'(m_active)}) begin
        bad++; $display("FAIL b2b_model[%0d]: got %h %b%b%b%b a=%0d want %h %b%b%b%b a=%0d", i,
          out, out_valid, sel_ready, sel_done, sel_err, active_sel, m_out, m_valid, m_ready, m_done, m_err, m_active);
      end
    end
    sel_valid = 1'b0;
    total++;
    if (dones != 4) begin
      bad++; $display("FAIL b2b_done_count: got %0d want 4", dones);
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_blank();
    int dones = 0;
    in_data = {8'h66, 8'h55, 8'h44};
    repeat (4) tick();
    sel_in = (m_active == 1) ? 2'd2 : 2'd1;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if ({out, out_valid, sel_ready, sel_done, active_sel} !== {8'h00, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      bad++; $display("FAIL midblank_reset: out=%h v=%b r=%b d=%b a=%0d", out, out_valid, sel_ready, sel_done, active_sel);
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < SYNC_STAGES + 3; i++) begin
      tick();
      if (sel_done === 1'b1) dones++;
      total++;
      if ({out, out_valid, sel_ready, sel_done, sel_err, active_sel} !== {m_out, m_valid, m_ready, m_done, m_err, SEL_W'(m_active)}) begin
        bad++; $display("FAIL midblank_model[%0d]: got %h %b%b%b%b a=%0d want %h %b%b%b%b a=%0d", i,
          out, out_valid, sel_ready, sel_done, sel_err, active_sel, m_out, m_valid, m_ready, m_done, m_err, m_active);
      end
    end
    total++;
    if ({out, out_valid, active_sel} !== {8'h44, 1'b1, 2'd0} || dones != 0) begin
      bad++; $display("FAIL midblank_after: out=%h v=%b a=%0d dones=%0d, want 44 1 0 0", out, out_valid, active_sel, dones);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_data   = DW'($urandom);
      sel_valid = ($urandom_range(0, 2) == 0);
      sel_in    = SEL_W'($urandom_range(0, 3));
      tick();
      total++;
      if ({out, out_valid, sel_ready, sel_done, sel_err, active_sel} !== {m_out, m_valid, m_ready, m_done, m_err, SEL_W'(m_active)}) begin
        bad++; $display("FAIL random[%0d]: got %h %b%b%b%b a=%0d want %h %b%b%b%b a=%0d", i,
          out, out_valid, sel_ready, sel_done, sel_err, active_sel, m_out, m_valid, m_ready, m_done, m_err, m_active);
      end
    end
    sel_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_switch();
    test_same_channel();
    test_reject();
    test_blank_value();
    test_back_to_back();
    test_reset_mid_blank();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sig_switch_nch.md
Name: sig_switch_nch

Overview:
Parametrised N-channel, W-bit registered signal switch; successor to the 2:1 synchronised mux in the digital signal switch path. Each channel passes through a configurable synchroniser chain. A valid/ready select handshake reroutes the registered output, with a break-before-make blanking gap so no mixed or partial word ever appears on OUT. Sits between asynchronous source inputs and downstream sampling logic.

Parameters:
NUM_CH, 4, number of input channels (>=2)
WIDTH, 8, bits per channel
SYNC_STAGES, 2, synchroniser flops per input bit (>=1)
GAP_CYCLES, 2, blanking cycles on a channel change (>=1)
RESET_SEL, 0, channel routed after reset (<NUM_CH)
Localparam SEL_W = max(1, clog2(NUM_CH)).

Ports:
CLK  in  1  system clock, 50 MHz
RST  in  1  asynchronous, active-high reset
IN_DATA  in  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
SEL_VALID  in  1  select request valid
SEL_IN  in  SEL_W  requested channel
SEL_READY  out  1  switch can accept a request
SEL_DONE  out  1  1-cycle pulse: request completed
SEL_ERR  out  1  1-cycle pulse: request rejected (SEL_IN >= NUM_CH)
ACTIVE_SEL  out  SEL_W  currently routed channel
OUT  out  WIDTH  registered switched data
OUT_VALID  out  1  OUT carries routed channel data

Behaviour:
- Reset: asynchronous, active-high. Takes effect immediately, independent of CLK.
  - Reset values: all synchroniser flops 0, OUT 0, OUT_VALID 0, SEL_DONE 0, SEL_ERR 0, ACTIVE_SEL = RESET_SEL, state ROUTE.
  - SEL_READY is 0 while RST is high and 1 from the first cycle after release.
- Synchroniser: every IN_DATA bit passes through SYNC_STAGES flops.
  - Latency from IN_DATA to OUT while routed: SYNC_STAGES+1 cycles.
- FSM states: ROUTE, BLANK.
- ROUTE state:
  - On each edge, OUT <= synced[ACTIVE_SEL] and OUT_VALID <= 1.
  - SEL_READY = 1.
- Request accepted on an edge with SEL_VALID && SEL_READY:
  - SEL_IN >= NUM_CH: reject, SEL_ERR pulses next cycle, state stays ROUTE, routing unchanged.
  - SEL_IN == ACTIVE_SEL: no blanking, SEL_DONE pulses next cycle, OUT continues uninterrupted.
  - Any other channel: latch SEL_IN as pending and go to BLANK.
- BLANK state:
  - Lasts exactly GAP_CYCLES cycles, starting the cycle after acceptance.
  - OUT = 0, OUT_VALID = 0, SEL_READY = 0. SEL_VALID is ignored, not queued.
  - A down-counter loaded with GAP_CYCLES-1 at acceptance sets the duration.
- Exit from BLANK: the cycle after the last blank cycle is the first ROUTE cycle. In that cycle:
  - ACTIVE_SEL = pending channel.
  - OUT = synced data of the new channel, OUT_VALID = 1.
  - SEL_DONE = 1 for that one cycle.
  - SEL_READY = 1, so a new request may be accepted in that same cycle.
- SEL_DONE and SEL_ERR never assert together. Each is high for exactly 1 cycle per request.
- Reset mid-BLANK: the pending request is discarded, no SEL_DONE, routing returns to RESET_SEL.
- SEL_IN is sampled only at acceptance; changes during BLANK have no effect.
- Non-power-of-two NUM_CH: out-of-range codes are always rejected; no wrap-around or modulo.

Optional Feature:
SWITCH_HOLD_LAST_EN
- Defined: during BLANK, OUT holds the last value routed before acceptance instead of 0. OUT_VALID is still 0 during BLANK. All other timing is unchanged.
- Undefined: OUT is forced to 0 throughout BLANK.

Test Plan:
- Reset, then release with RESET_SEL=0 and IN_DATA ch0=0x5A -> OUT=0 and OUT_VALID=0 during reset; OUT=0x5A, OUT_VALID=1 after SYNC_STAGES+1 edges; ACTIVE_SEL=0, SEL_READY=1.
- ch0=0x11, ch2=0x33; request SEL_IN=2 -> SEL_READY=0 and OUT_VALID=0, OUT=0x00 for exactly 2 cycles; next cycle OUT=0x33, ACTIVE_SEL=2, SEL_DONE=1 for 1 cycle.
- Request SEL_IN=ACTIVE_SEL=2 -> no blanking; OUT stays 0x33 continuously; SEL_DONE pulses 1 cycle later.
- NUM_CH=3, request SEL_IN=3 -> SEL_ERR pulses 1 cycle; ACTIVE_SEL unchanged; OUT_VALID stays 1.
- Accept SEL_IN=1, assert RST on the 1st blank cycle -> OUT=0, no SEL_DONE; after release ACTIVE_SEL=0 and ch0 is routed.
- SWITCH_HOLD_LAST_EN build, OUT=0x33, switch to ch1=0x22 -> OUT=0x33 with OUT_VALID=0 for 2 cycles, then OUT=0x22 with OUT_VALID=1.
